// File: rtl/game_renderer.sv
// Pong game core: ball, paddles and scores advance once per frame on the vsync
// falling edge; a registered colour generator paints the current pixel.
//  state | meaning
//  SERVE | ball parked at centre, counting frames until launch
//  PLAY  | ball moving; walls, paddles and misses evaluated every frame
module game_renderer #(
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480,
   parameter int BALL_SIZE    = 8,
   parameter int PADDLE_H     = 64,
   parameter int PADDLE_SPEED = 4,
   parameter int SERVE_FRAMES = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  x_pos,
   input  logic [9:0]  y_pos,
   input  logic        display_on,
   input  logic        vsync,
   input  logic        btn_up,
   input  logic        btn_down,
   output logic [11:0] rgb,
   output logic [3:0]  score_l,
   output logic [3:0]  score_r
);
   typedef enum logic {SERVE, PLAY} state_t;

   localparam logic [9:0]         BALL_X0    = 10'd316;
   localparam logic [9:0]         BALL_Y0    = 10'd236;
   localparam logic [9:0]         PADDLE_Y0  = 10'd208;
   localparam logic signed [10:0] MISS_R     = 11'(H_ACTIVE - BALL_SIZE);
   localparam logic signed [10:0] WALL_B     = 11'(V_ACTIVE - BALL_SIZE);
   localparam logic [9:0]         WALL_B_U   = 10'(V_ACTIVE - BALL_SIZE);
   localparam logic signed [10:0] BS_S       = 11'(BALL_SIZE);
   localparam logic [10:0]        BS_U       = 11'(BALL_SIZE);
   localparam logic [10:0]        PH_U       = 11'(PADDLE_H);
   localparam logic [9:0]         PADDLE_MAX = 10'(V_ACTIVE - PADDLE_H);
   localparam logic [9:0]         PSPEED     = 10'(PADDLE_SPEED);
   localparam logic [15:0]        SERVE_LAST = 16'(SERVE_FRAMES - 1);
   localparam logic signed [11:0] BALL_HALF  = 12'(BALL_SIZE / 2);
   localparam logic signed [11:0] PAD_HALF   = 12'(PADDLE_H / 2);

   state_t      state_q, state_d;
   logic [15:0] serve_cnt_q, serve_cnt_d;
   logic [9:0]  ball_x_q, ball_x_d, ball_y_q, ball_y_d;
   logic        dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
   logic [9:0]  paddle_l_q, paddle_l_d, paddle_r_q, paddle_r_d;
   logic [3:0]  score_l_q, score_l_d, score_r_q, score_r_d;
   logic        vsync_q;
   logic [11:0] rgb_q, pixel_rgb;

   logic               frame_tick;
   logic signed [10:0] nx, ny;
   logic               ov_l, ov_r;
   logic signed [11:0] track_diff;
   logic               in_ball, in_pad_l, in_pad_r, in_centre;

   assign frame_tick = vsync_q & ~vsync;
   assign nx = $signed({1'b0, ball_x_q}) + (dx_neg_q ? -11'sd2 : 11'sd2);
   assign ny = $signed({1'b0, ball_y_q}) + (dy_neg_q ? -11'sd2 : 11'sd2);
   assign ov_l = (({1'b0, ball_y_q} + BS_U) > {1'b0, paddle_l_q}) &&
                 ({1'b0, ball_y_q} < ({1'b0, paddle_l_q} + PH_U));
   assign ov_r = (({1'b0, ball_y_q} + BS_U) > {1'b0, paddle_r_q}) &&
                 ({1'b0, ball_y_q} < ({1'b0, paddle_r_q} + PH_U));
   // positive when the ball centre is below the right paddle centre
   assign track_diff = ($signed({2'b0, ball_y_q}) + BALL_HALF) -
                       ($signed({2'b0, paddle_r_q}) + PAD_HALF);

   always_comb begin
      state_d     = state_q;
      serve_cnt_d = serve_cnt_q;
      ball_x_d    = ball_x_q;
      ball_y_d    = ball_y_q;
      dx_neg_d    = dx_neg_q;
      dy_neg_d    = dy_neg_q;
      paddle_l_d  = paddle_l_q;
      paddle_r_d  = paddle_r_q;
      score_l_d   = score_l_q;
      score_r_d   = score_r_q;
      if (frame_tick) begin
         case (state_q)
            SERVE: begin
               ball_x_d = BALL_X0;
               ball_y_d = BALL_Y0;
               if (serve_cnt_q == SERVE_LAST) begin
                  state_d     = PLAY;
                  serve_cnt_d = '0;
               end else begin
                  serve_cnt_d = serve_cnt_q + 16'd1;
               end
            end
            PLAY: begin
               // a miss overrides any wall or paddle bounce in the same frame
               if (nx <= 11'sd0) begin
                  score_r_d = (score_r_q == 4'd9) ? 4'd0 : score_r_q + 4'd1;
                  state_d   = SERVE;
                  ball_x_d  = BALL_X0;
                  ball_y_d  = BALL_Y0;
                  dx_neg_d  = 1'b1;
                  dy_neg_d  = 1'b0;
               end else if (nx >= MISS_R) begin
                  score_l_d = (score_l_q == 4'd9) ? 4'd0 : score_l_q + 4'd1;
                  state_d   = SERVE;
                  ball_x_d  = BALL_X0;
                  ball_y_d  = BALL_Y0;
                  dx_neg_d  = 1'b0;
                  dy_neg_d  = 1'b0;
               end else begin
                  if (ny <= 11'sd0) begin
                     ball_y_d = '0;
                     dy_neg_d = 1'b0;
                  end else if (ny >= WALL_B) begin
                     ball_y_d = WALL_B_U;
                     dy_neg_d = 1'b1;
                  end else begin
                     ball_y_d = ny[9:0];
                  end
                  if (dx_neg_q && nx <= 11'sd24 && nx >= 11'sd16 && ov_l) begin
                     ball_x_d = 10'd24;
                     dx_neg_d = 1'b0;
                  end else if (!dx_neg_q && (nx + BS_S) >= 11'sd616 &&
                               nx <= 11'sd616 && ov_r) begin
                     ball_x_d = 10'd608;
                     dx_neg_d = 1'b1;
                  end else begin
                     ball_x_d = nx[9:0];
                  end
               end
            end
         endcase

         if (btn_up && !btn_down)
            paddle_l_d = (paddle_l_q < PSPEED) ? 10'd0 : paddle_l_q - PSPEED;
         else if (btn_down && !btn_up)
            paddle_l_d = (paddle_l_q > PADDLE_MAX - PSPEED) ? PADDLE_MAX
                                                            : paddle_l_q + PSPEED;

         if (track_diff > 12'sd2)
            paddle_r_d = (paddle_r_q > PADDLE_MAX - 10'd2) ? PADDLE_MAX
                                                          : paddle_r_q + 10'd2;
         else if (track_diff < -12'sd2)
            paddle_r_d = (paddle_r_q < 10'd2) ? 10'd0 : paddle_r_q - 10'd2;
      end
   end

   assign in_ball   = (x_pos >= ball_x_q) && ({1'b0, x_pos} < ({1'b0, ball_x_q} + BS_U)) &&
                      (y_pos >= ball_y_q) && ({1'b0, y_pos} < ({1'b0, ball_y_q} + BS_U));
   assign in_pad_l  = (x_pos >= 10'd16) && (x_pos <= 10'd23) && (y_pos >= paddle_l_q) &&
                      ({1'b0, y_pos} < ({1'b0, paddle_l_q} + PH_U));
   assign in_pad_r  = (x_pos >= 10'd616) && (x_pos <= 10'd623) && (y_pos >= paddle_r_q) &&
                      ({1'b0, y_pos} < ({1'b0, paddle_r_q} + PH_U));
   assign in_centre = (x_pos >= 10'd318) && (x_pos <= 10'd321) && !y_pos[4];

   always_comb begin
      pixel_rgb = 12'h000;
      if (!display_on)    pixel_rgb = 12'h000;
      else if (in_ball)   pixel_rgb = 12'hFFF;
      else if (in_pad_l)  pixel_rgb = 12'h0FF;
      else if (in_pad_r)  pixel_rgb = 12'hF0F;
      else if (in_centre) pixel_rgb = 12'h888;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SERVE;
         serve_cnt_q <= '0;
         ball_x_q    <= BALL_X0;
         ball_y_q    <= BALL_Y0;
         dx_neg_q    <= 1'b0;
         dy_neg_q    <= 1'b0;
         paddle_l_q  <= PADDLE_Y0;
         paddle_r_q  <= PADDLE_Y0;
         score_l_q   <= '0;
         score_r_q   <= '0;
         vsync_q     <= 1'b1;
         rgb_q       <= '0;
      end else begin
         state_q     <= state_d;
         serve_cnt_q <= serve_cnt_d;
         ball_x_q    <= ball_x_d;
         ball_y_q    <= ball_y_d;
         dx_neg_q    <= dx_neg_d;
         dy_neg_q    <= dy_neg_d;
         paddle_l_q  <= paddle_l_d;
         paddle_r_q  <= paddle_r_d;
         score_l_q   <= score_l_d;
         score_r_q   <= score_r_d;
         vsync_q     <= vsync;
         rgb_q       <= pixel_rgb;
      end
   end

   assign rgb     = rgb_q;
   assign score_l = score_l_q;
   assign score_r = score_r_q;
endmodule

// File: tb/tb_game_renderer.sv
// Bench for game_renderer: directed reset/serve/paddle/blanking checks, then
// randomized frames compared pixel-by-pixel against an integer game model.
module tb_game_renderer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  x_pos = '0;
   logic [9:0]  y_pos = '0;
   logic        display_on = 1'b0;
   logic        vsync = 1'b1;
   logic        btn_up = 1'b0;
   logic        btn_down = 1'b0;
   logic [11:0] rgb;
   logic [3:0]  score_l, score_r;

   always #10 clk = ~clk;

   game_renderer dut (
      .clk(clk), .rst(rst), .x_pos(x_pos), .y_pos(y_pos),
      .display_on(display_on), .vsync(vsync), .btn_up(btn_up),
      .btn_down(btn_down), .rgb(rgb), .score_l(score_l), .score_r(score_r)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // game model: plain integers, whole-frame semantics
   int m_play, m_cnt, m_bx, m_by, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr;

   function automatic void model_reset();
      m_play = 0; m_cnt = 0; m_bx = 316; m_by = 236; m_dx = 2; m_dy = 2;
      m_pl = 208; m_pr = 208; m_sl = 0; m_sr = 0;
   endfunction

   function automatic bit overlaps(input int by, input int py);
      return (by + 8 > py) && (by < py + 64);
   endfunction

   function automatic void model_tick(input bit up, input bit down);
      int bx = m_bx, by = m_by, pl = m_pl, pr = m_pr;
      int nx = bx + m_dx, ny = by + m_dy;
      int bc = by + 4, pc = pr + 32;
      if (!m_play) begin
         if (m_cnt == 59) begin m_play = 1; m_cnt = 0; end
         else m_cnt++;
      end else if (nx <= 0) begin
         m_sr = (m_sr + 1) % 10; m_play = 0;
         m_bx = 316; m_by = 236; m_dx = -2; m_dy = 2;
      end else if (nx >= 632) begin
         m_sl = (m_sl + 1) % 10; m_play = 0;
         m_bx = 316; m_by = 236; m_dx = 2; m_dy = 2;
      end else begin
         if (ny <= 0)        begin m_by = 0;   m_dy = 2;  end
         else if (ny >= 472) begin m_by = 472; m_dy = -2; end
         else m_by = ny;
         if (m_dx < 0 && nx <= 24 && nx >= 16 && overlaps(by, pl)) begin
            m_bx = 24; m_dx = 2;
         end else if (m_dx > 0 && nx + 8 >= 616 && nx <= 616 && overlaps(by, pr)) begin
            m_bx = 608; m_dx = -2;
         end else m_bx = nx;
      end
      if (up && !down)      m_pl = (pl - 4 < 0) ? 0 : pl - 4;
      else if (down && !up) m_pl = (pl + 4 > 416) ? 416 : pl + 4;
      if (bc - pc > 2)      m_pr = (pr + 2 > 416) ? 416 : pr + 2;
      else if (pc - bc > 2) m_pr = (pr - 2 < 0) ? 0 : pr - 2;
   endfunction

   function automatic logic [11:0] model_rgb(input int x, input int y, input bit de);
      if (!de) return 12'h000;
      if (x >= m_bx && x < m_bx + 8 && y >= m_by && y < m_by + 8) return 12'hFFF;
      if (x >= 16 && x <= 23 && y >= m_pl && y < m_pl + 64) return 12'h0FF;
      if (x >= 616 && x <= 623 && y >= m_pr && y < m_pr + 64) return 12'hF0F;
      if (x >= 318 && x <= 321 && ((y / 16) % 2) == 0) return 12'h888;
      return 12'h000;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input string tag, input int x, input int y, input bit de);
      x_pos = 10'(x); y_pos = 10'(y); display_on = de;
      step();
      chk(tag, rgb, model_rgb(x, y, de));
   endtask

   task automatic frame(input bit up, input bit down);
      btn_up = up; btn_down = down; vsync = 1'b0;
      step();
      model_tick(up, down);
      vsync = 1'b1;
      step();
      chk("score_l", {8'h00, score_l}, 12'(m_sl));
      chk("score_r", {8'h00, score_r}, 12'(m_sr));
   endtask

   task automatic do_reset(input bit with_tick);
      rst = 1'b1; vsync = with_tick ? 1'b0 : 1'b1;
      step();
      vsync = 1'b1;
      step();
      rst = 1'b0;
      model_reset();
   endtask

   task automatic probe_scene();
      probe("ball_tl", m_bx, m_by, 1'b1);
      probe("ball_br", m_bx + 7, m_by + 7, 1'b1);
      if (m_bx + 8 < 640) probe("ball_right", m_bx + 8, m_by, 1'b1);
      if (m_by > 0)       probe("ball_above", m_bx, m_by - 1, 1'b1);
      probe("pad_l_top", 16, m_pl, 1'b1);
      probe("pad_l_bot", 23, m_pl + 63, 1'b1);
      if (m_pl > 0)       probe("pad_l_above", 20, m_pl - 1, 1'b1);
      if (m_pl + 64 < 480) probe("pad_l_below", 20, m_pl + 64, 1'b1);
      probe("pad_r_top", 616, m_pr, 1'b1);
      if (m_pr + 64 < 480) probe("pad_r_below", 619, m_pr + 64, 1'b1);
      probe("random_px", $urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom_range(0, 3) != 0));
   endtask

   initial begin
      int rst_frame;
      int r;
      do_reset(1'b0);
      probe("rst_ball", 316, 236, 1'b1);
      chk("rst_ball_const", rgb, 12'hFFF);
      chk("rst_score_l", {8'h00, score_l}, 12'h000);
      chk("rst_score_r", {8'h00, score_r}, 12'h000);
      probe("blank_ball", 316, 236, 1'b0);
      chk("blank_ball_const", rgb, 12'h000);
      probe("centre_gap", 319, 16, 1'b1);
      chk("centre_gap_const", rgb, 12'h000);
      probe("centre_dash", 319, 0, 1'b1);
      chk("centre_dash_const", rgb, 12'h888);

      for (int i = 0; i < 60; i++) frame(1'b0, 1'b1);
      probe("pad_clamp", 16, 416, 1'b1);
      chk("pad_clamp_const", rgb, 12'h0FF);
      probe("pad_clamp_above", 20, 415, 1'b1);
      chk("pad_clamp_above_const", rgb, 12'h000);
      probe("serve_ball", 316, 236, 1'b1);

      frame(1'b1, 1'b1);
      probe("first_move", 318, 238, 1'b1);
      chk("first_move_const", rgb, 12'hFFF);
      probe("first_move_left", 317, 238, 1'b1);
      chk("first_move_left_const", rgb, 12'h000);
      probe("pad_both", 16, 416, 1'b1);
      chk("pad_both_const", rgb, 12'h0FF);

      rst_frame = $urandom_range(2000, 2600);
      for (int f = 0; f < 2800; f++) begin
         if (f == rst_frame) begin
            do_reset(1'b1);
            probe("mid_rst_ball", 316, 236, 1'b1);
            chk("mid_rst_score_l", {8'h00, score_l}, 12'h000);
            chk("mid_rst_score_r", {8'h00, score_r}, 12'h000);
         end
         r = $urandom_range(0, 3);
         frame(r == 1 || r == 3, r == 2 || r == 3);
         probe_scene();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/game_renderer.md
GAME_RENDERER -- requirements
Module: game_renderer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-003 SHALL have parameter BALL_SIZE, default 8: ball edge length in pixels.
REQ-004 SHALL have parameter PADDLE_H, default 64: paddle height in pixels; paddle width is fixed at 8.
REQ-005 SHALL have parameter PADDLE_SPEED, default 4: pixels per frame for the left paddle; the right paddle moves at 2.
REQ-006 SHALL have parameter SERVE_FRAMES, default 60: frames of delay before each serve.
REQ-007 SHALL have port clk, input, 1 bit: single clock, same clock as vga_controller (50 MHz).
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-009 SHALL have ports x_pos and y_pos, input, 10 bits each: current pixel coordinates from vga_controller.
REQ-010 SHALL have port display_on, input, 1 bit: visible-area flag from vga_controller.
REQ-011 SHALL have port vsync, input, 1 bit: active-low vertical sync from vga_controller.
REQ-012 SHALL have ports btn_up and btn_down, input, 1 bit each: left-paddle controls, already synchronised, active-high.
REQ-013 SHALL have port rgb, output, 12 bits: pixel colour as {R[3:0],G[3:0],B[3:0]}, registered.
REQ-014 SHALL have ports score_l and score_r, output, 4 bits each: BCD scores, 0-9.

Function
REQ-015 SHALL register vsync; frame_tick SHALL be a one-cycle pulse on the vsync 1->0 transition. All game state SHALL update only on frame_tick.
REQ-016 SHALL implement FSM states SERVE and PLAY.
- SERVE: ball at (316,236); serve counter increments per frame_tick; at SERVE_FRAMES-1 the FSM enters PLAY and the counter clears.
REQ-017 Serve velocity SHALL be |dx| = |dy| = 2 and dy = +2. dx SHALL point toward the player who conceded the last point. After reset, dx = +2.
REQ-018 In PLAY, each frame_tick SHALL compute nx = ball_x+dx and ny = ball_y+dy, with signed 11-bit arithmetic.
REQ-019 Top and bottom walls:
- ny <= 0: ball_y=0, dy=+2.
- ny >= V_ACTIVE-BALL_SIZE: ball_y=V_ACTIVE-BALL_SIZE, dy=-2.
REQ-020 Left paddle occupies x 16..23. Vertical overlap means ball_y+BALL_SIZE > paddle_y and ball_y < paddle_y+PADDLE_H.
- Condition: dx<0, nx<=24, nx>=16, and vertical overlap.
- Action: ball_x=24, dx=+2.
REQ-021 Right paddle occupies x 616..623.
- Condition: dx>0, nx+BALL_SIZE>=616, nx<=616, and vertical overlap.
- Action: ball_x=608, dx=-2.
REQ-022 Misses:
- nx<=0: score_r increments and the FSM enters SERVE.
- nx>=H_ACTIVE-BALL_SIZE: score_l increments and the FSM enters SERVE.
- A wall bounce and a miss in the same tick: the miss SHALL take priority.
REQ-023 Scores SHALL wrap 9->0. The increment and the SERVE entry SHALL occur on the same frame_tick.
REQ-024 Left paddle_y SHALL change once per frame_tick in every state.
- btn_up only: paddle_y -= PADDLE_SPEED, clamped at 0.
- btn_down only: paddle_y += PADDLE_SPEED, clamped at V_ACTIVE-PADDLE_H.
- Both or neither pressed: no move.
REQ-025 Right paddle_y SHALL move 2 per frame_tick toward the ball.
- Target: paddle centre equals ball centre.
- No move if the centres are within 2 of each other.
- Same clamps as the left paddle.
REQ-026 Rendering priority per pixel, first match wins:
- display_on=0 -> 12'h000.
- Ball -> 12'hFFF.
- Left paddle -> 12'h0FF.
- Right paddle -> 12'hF0F.
- Centre line (x 318..321 and y_pos[4]=0) -> 12'h888.
- Otherwise -> 12'h000.
REQ-027 rgb SHALL have exactly one clock of latency: rgb in cycle n+1 reflects x_pos, y_pos and display_on of cycle n.
REQ-028 Object positions SHALL change only on frame_tick, which occurs during blanking, so no visible frame tears.

Reset
REQ-029 On rst=1 at a clk edge, the block SHALL enter the following state:
- rgb=0, score_l=0, score_r=0.
- FSM=SERVE, serve counter=0, ball at (316,236), dx=+2, dy=+2.
- Both paddles at y=208.
- Registered vsync=1.
REQ-030 Reset asserted mid-PLAY or mid-SERVE SHALL override every pending update, including a frame_tick in the same cycle.

Verification
REQ-031 Reset: rst high 2 cycles, then drive x=316, y=236, display_on=1 -> next cycle rgb=FFF; scores=0.
REQ-032 Serve: 60 vsync falling edges, no buttons -> FSM enters PLAY; after one more frame_tick the ball is at (318,238).
REQ-033 Wall: in PLAY with ball_y=472 and dy=+2, apply a frame_tick -> ball_y=472, dy=-2; apply the next tick -> ball_y=470.
REQ-034 Miss: left paddle held at y=0 via btn_up, ball travelling left at y=400 -> score_r=1 on the tick where nx<=0; FSM enters SERVE; the next serve has dx=-2.
REQ-035 Paddle: hold btn_down for 60 frames from reset -> paddle_y=416 (clamped); press both buttons -> no change.
REQ-036 Blanking and latency: display_on=0 at a ball pixel -> rgb=000 one cycle later; x=319, y=16, display_on=1 -> rgb=000; x=319, y=0 -> rgb=888.
